// File: rtl/vga_capture.sv
// vga_capture: decodes a sampled VGA stream, verifies line/frame timing and
// emits one write strobe per kept pixel of a centred, block-decimated grid.
// H_ACT/V_ACT give the active geometry of the incoming stream (640x480 for
// real VGA); they exist so reduced-size streams can exercise the same logic.
module vga_capture #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned H_ACT  = 640,
    parameter int unsigned V_ACT  = 480
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic       VGA_BLANK_N,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       valid,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam int unsigned X_BLOCK = H_ACT / WIDTH;
    localparam int unsigned Y_BLOCK = V_ACT / HEIGHT;
    localparam int unsigned BLOCK   = (X_BLOCK < Y_BLOCK) ? X_BLOCK : Y_BLOCK;
    localparam int unsigned X_SPAN  = WIDTH * BLOCK;
    localparam int unsigned Y_SPAN  = HEIGHT * BLOCK;
    localparam int unsigned X_START = (H_ACT - X_SPAN) / 2;
    localparam int unsigned Y_START = (V_ACT - Y_SPAN) / 2;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_CHECK  = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_d;

    logic       r_vs_prev;
    logic       r_bl_prev;
    logic [9:0] r_px;
    logic [8:0] r_ln;
    logic [9:0] r_xd;
    logic [9:0] r_xc;
    logic [8:0] r_yd;
    logic [8:0] r_yc;

    logic       w_vs_fall;
    logic       w_bl_fall;
    logic [9:0] w_px_off;
    logic [8:0] w_ln_off;
    logic       w_in_x;
    logic       w_in_y;
    logic       w_keep;
    logic [8:0] w_ln_end;
    logic       w_line_bad;
    logic       w_frame_bad;
    logic       w_locked_d;
    logic       w_sync_err_d;
    logic       w_frame_start_d;
    logic       w_unused_hs;

    // HS carries no information needed for position recovery
    assign w_unused_hs = VGA_HS;

    // Edge detection, window test and timing checks for the current sample
    always_comb begin
        w_vs_fall   = pix_en & r_vs_prev & ~VGA_VS;
        w_bl_fall   = pix_en & r_bl_prev & ~VGA_BLANK_N;
        // Offset compare: below-start values wrap far above the span
        w_px_off    = r_px - 10'(X_START);
        w_ln_off    = r_ln - 9'(Y_START);
        w_in_x      = (w_px_off < 10'(X_SPAN));
        w_in_y      = (w_ln_off < 9'(Y_SPAN));
        w_keep      = pix_en & VGA_BLANK_N & (r_state == S_RUN) & w_in_x & w_in_y
                      & (r_xd == 10'd0) & (r_yd == 9'd0);
        // A line ending in the same sample as VS still counts toward the frame
        w_ln_end    = w_bl_fall ? 9'(r_ln + 9'd1) : r_ln;
        w_line_bad  = w_bl_fall & (r_px != 10'(H_ACT));
        w_frame_bad = w_vs_fall & (w_ln_end != 9'(V_ACT));
    end

    // Lock FSM: state register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Lock FSM: next state and next values of the status outputs
    always_comb begin
        w_state_d       = r_state;
        w_locked_d      = locked;
        w_sync_err_d    = 1'b0;
        w_frame_start_d = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_fall) begin
                    w_state_d = S_CHECK;
                end
            end
            S_CHECK, S_RUN: begin
                if (w_line_bad || w_frame_bad) begin
                    w_state_d    = S_SEARCH;
                    w_locked_d   = 1'b0;
                    w_sync_err_d = 1'b1;
                end else if (w_vs_fall) begin
                    w_state_d       = S_RUN;
                    w_locked_d      = 1'b1;
                    w_frame_start_d = 1'b1;
                end
            end
            default: begin
                w_state_d  = S_SEARCH;
                w_locked_d = 1'b0;
            end
        endcase
    end

    // Previous-sample registers and raw pixel/line counters
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_prev <= 1'b0;
            r_bl_prev <= 1'b0;
            r_px      <= 10'd0;
            r_ln      <= 9'd0;
        end else if (pix_en) begin
            r_vs_prev <= VGA_VS;
            r_bl_prev <= VGA_BLANK_N;
            if (w_bl_fall) begin
                r_px <= 10'd0;
            end else if (VGA_BLANK_N) begin
                r_px <= r_px + 10'd1;
            end
            if (w_vs_fall) begin
                r_ln <= 9'd0;
            end else if (w_bl_fall) begin
                r_ln <= r_ln + 9'd1;
            end
        end
    end

    // Sub-block and logical coordinate counters for decimation
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_xd <= 10'd0;
            r_xc <= 10'd0;
            r_yd <= 9'd0;
            r_yc <= 9'd0;
        end else if (pix_en) begin
            if (w_vs_fall) begin
                r_xd <= 10'd0;
                r_xc <= 10'd0;
                r_yd <= 9'd0;
                r_yc <= 9'd0;
            end else if (w_bl_fall) begin
                r_xd <= 10'd0;
                r_xc <= 10'd0;
                if (w_in_y) begin
                    if (r_yd == 9'(BLOCK - 1)) begin
                        r_yd <= 9'd0;
                        r_yc <= r_yc + 9'd1;
                    end else begin
                        r_yd <= r_yd + 9'd1;
                    end
                end
            end else if (VGA_BLANK_N && w_in_x && w_in_y) begin
                if (r_xd == 10'(BLOCK - 1)) begin
                    r_xd <= 10'd0;
                    r_xc <= r_xc + 10'd1;
                end else begin
                    r_xd <= r_xd + 10'd1;
                end
            end
        end
    end

    // Registered outputs: strobes are one cycle, pixel data holds until next strobe
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            x           <= 10'd0;
            y           <= 9'd0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            valid       <= w_keep;
            frame_start <= w_frame_start_d;
            locked      <= w_locked_d;
            sync_err    <= w_sync_err_d;
            if (w_keep) begin
                x <= r_xc;
                y <= r_yc;
                r <= VGA_R;
                g <= VGA_G;
                b <= VGA_B;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames on a reduced 16x12-active stream
// (24 samples/line, 18 lines/frame) driven into three decimation setups.
module tb_vga_capture;

    logic       clk;
    logic       rst_n;
    logic       pix_en;
    logic [7:0] vr, vg, vb;
    logic       hs, vs, bl;

    logic [9:0] o_x     [3];
    logic [8:0] o_y     [3];
    logic [7:0] o_r     [3];
    logic [7:0] o_g     [3];
    logic [7:0] o_b     [3];
    logic       o_valid [3];
    logic       o_fs    [3];
    logic       o_lk    [3];
    logic       o_se    [3];

    // Instance 0: 16x12 (BLOCK 1), 1: 8x6 (BLOCK 2), 2: 5x5 (BLOCK 2, start 3,1)
    int xs_c  [3] = '{0, 0, 3};
    int ys_c  [3] = '{0, 0, 1};
    int blk_c [3] = '{1, 2, 2};

    int n_cmp = 0;
    int n_err = 0;

    int cnt     [3];
    int fx      [3];
    int fy      [3];
    int lx      [3];
    int ly      [3];
    int fs_cnt  [3];
    int se_cnt  [3];
    int se_lk   [3];
    int map_err [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_capture #(.WIDTH(16), .HEIGHT(12), .H_ACT(16), .V_ACT(12)) u_full (
        .CLOCK_50(clk), .reset_n(rst_n), .pix_en(pix_en),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bl),
        .x(o_x[0]), .y(o_y[0]), .r(o_r[0]), .g(o_g[0]), .b(o_b[0]),
        .valid(o_valid[0]), .frame_start(o_fs[0]), .locked(o_lk[0]), .sync_err(o_se[0])
    );

    vga_capture #(.WIDTH(8), .HEIGHT(6), .H_ACT(16), .V_ACT(12)) u_half (
        .CLOCK_50(clk), .reset_n(rst_n), .pix_en(pix_en),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bl),
        .x(o_x[1]), .y(o_y[1]), .r(o_r[1]), .g(o_g[1]), .b(o_b[1]),
        .valid(o_valid[1]), .frame_start(o_fs[1]), .locked(o_lk[1]), .sync_err(o_se[1])
    );

    vga_capture #(.WIDTH(5), .HEIGHT(5), .H_ACT(16), .V_ACT(12)) u_ctr (
        .CLOCK_50(clk), .reset_n(rst_n), .pix_en(pix_en),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bl),
        .x(o_x[2]), .y(o_y[2]), .r(o_r[2]), .g(o_g[2]), .b(o_b[2]),
        .valid(o_valid[2]), .frame_start(o_fs[2]), .locked(o_lk[2]), .sync_err(o_se[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; fx[i] = -1; fy[i] = -1; lx[i] = -1; ly[i] = -1;
            fs_cnt[i] = 0; se_cnt[i] = 0; se_lk[i] = 0; map_err[i] = 0;
        end
    endtask

    // Record strobes/pulses; a kept pixel must carry the raw colour of its block origin
    task automatic observe();
        int er, eg;
        for (int i = 0; i < 3; i++) begin
            if (o_valid[i]) begin
                if (cnt[i] == 0) begin
                    fx[i] = int'(o_x[i]);
                    fy[i] = int'(o_y[i]);
                end
                lx[i] = int'(o_x[i]);
                ly[i] = int'(o_y[i]);
                cnt[i]++;
                er = (xs_c[i] + int'(o_x[i]) * blk_c[i]) & 255;
                eg = (ys_c[i] + int'(o_y[i]) * blk_c[i]) & 255;
                if (int'(o_r[i]) != er || int'(o_g[i]) != eg || int'(o_b[i]) != (er ^ 8'h5A))
                    map_err[i]++;
            end
            if (o_fs[i]) fs_cnt[i]++;
            if (o_se[i]) begin
                se_cnt[i]++;
                if (o_lk[i]) se_lk[i]++;
            end
        end
    endtask

    // Inputs are scrambled while pix_en is low; the DUT must ignore them
    task automatic scramble(input logic hs_i, input logic vs_i, input logic bl_i);
        pix_en = 1'b0;
        vr = 8'($urandom); vg = 8'($urandom); vb = 8'($urandom);
        hs = ~hs_i; vs = ~vs_i; bl = ~bl_i;
    endtask

    task automatic sample(input logic [7:0] r_i, input logic [7:0] g_i,
                          input logic hs_i, input logic vs_i, input logic bl_i);
        @(negedge clk);
        pix_en = 1'b1;
        vr = r_i; vg = g_i; vb = r_i ^ 8'h5A;
        hs = hs_i; vs = vs_i; bl = bl_i;
        @(negedge clk);
        scramble(hs_i, vs_i, bl_i);
        observe();
    endtask

    task automatic idle(input int n);
        logic hs_k, vs_k, bl_k;
        hs_k = ~hs; vs_k = ~vs; bl_k = ~bl;
        repeat (n) begin
            @(negedge clk);
            scramble(hs_k, vs_k, bl_k);
            observe();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        int sum;
        for (int i = 0; i < 3; i++) begin
            sum = int'(o_x[i]) + int'(o_y[i]) + int'(o_r[i]) + int'(o_g[i]) + int'(o_b[i])
                + int'(o_valid[i]) + int'(o_fs[i]) + int'(o_lk[i]) + int'(o_se[i]);
            check($sformatf("u%0d.%s", i, tag), sum, 0);
        end
    endtask

    // Asynchronous reset between clock edges while locked
    task automatic reset_mid();
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d.locked_before_reset", i), int'(o_lk[i]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("outputs_in_async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Frame: 2 VS lines, 2 back porch, 12 active (16 px), 2 front porch
    task automatic send_frame(input int bad_act, input int gap_act, input int rst_act);
        int   a;
        int   n;
        logic act;
        clear_tally();
        for (int fl = 0; fl < 18; fl++) begin
            act = (fl >= 4) && (fl < 16);
            a   = act ? fl - 4 : 0;
            n   = !act ? 0 : ((a == bad_act) ? 15 : 16);
            if (act && a == rst_act) reset_mid();
            for (int s = 0; s < 24; s++) begin
                if (act && a == gap_act && s == 7) idle(50);
                sample(8'(s), 8'(a), !(s >= 18 && s <= 20), fl >= 2, s < n);
            end
        end
    endtask

    task automatic check_frame(input int f, input int i, input int e_cnt,
                               input int e_lx, input int e_ly, input int e_fs,
                               input int e_se, input int e_lk);
        string p;
        p = $sformatf("f%0d.u%0d.", f, i);
        check({p, "strobes"}, cnt[i], e_cnt);
        if (e_cnt > 0) begin
            check({p, "first_x"}, fx[i], 0);
            check({p, "first_y"}, fy[i], 0);
            check({p, "last_x"}, lx[i], e_lx);
            check({p, "last_y"}, ly[i], e_ly);
        end
        check({p, "colour_map_errors"}, map_err[i], 0);
        check({p, "frame_start_pulses"}, fs_cnt[i], e_fs);
        check({p, "sync_err_pulses"}, se_cnt[i], e_se);
        check({p, "locked_with_sync_err"}, se_lk[i], 0);
        check({p, "locked_at_end"}, int'(o_lk[i]), e_lk);
    endtask

    // kind 0: no capture, 1: full capture, 2: line 5 short, 3: reset at line 4
    task automatic frame_checks(input int f, input int kind);
        int full_cnt [3] = '{192, 48, 25};
        int full_lx  [3] = '{15, 7, 4};
        int full_ly  [3] = '{11, 5, 4};
        int bad_cnt  [3] = '{95, 24, 15};
        int bad_lx   [3] = '{14, 7, 4};
        int bad_ly   [3] = '{5, 2, 2};
        int rst_cnt  [3] = '{64, 16, 10};
        int rst_ly   [3] = '{3, 1, 1};
        for (int i = 0; i < 3; i++) begin
            case (kind)
                1:       check_frame(f, i, full_cnt[i], full_lx[i], full_ly[i], 1, 0, 1);
                2:       check_frame(f, i, bad_cnt[i], bad_lx[i], bad_ly[i], 1, 1, 0);
                3:       check_frame(f, i, rst_cnt[i], full_lx[i], rst_ly[i], 1, 0, 0);
                default: check_frame(f, i, 0, 0, 0, 0, 0, 0);
            endcase
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        vr = 8'd0; vg = 8'd0; vb = 8'd0;
        hs = 1'b1; vs = 1'b1; bl = 1'b0;
        repeat (4) @(negedge clk);
        check_zero_outputs("outputs_after_reset");
        rst_n = 1'b1;

        // Idle blank lines with VS high so the first VS edge is seen
        for (int s = 0; s < 48; s++) sample(8'd0, 8'd0, 1'b1, 1'b1, 1'b0);

        send_frame(-1, -1, -1); frame_checks(0, 0);  // CHECK frame
        send_frame(-1, -1, -1); frame_checks(1, 1);  // lock at VS, first capture
        send_frame(-1, 5, -1);  frame_checks(2, 1);  // 50-cycle pix_en gap
        send_frame(5, -1, -1);  frame_checks(3, 2);  // short line drops lock
        send_frame(-1, -1, -1); frame_checks(4, 0);  // re-check frame
        send_frame(-1, -1, -1); frame_checks(5, 1);  // captured again
        send_frame(-1, -1, 4);  frame_checks(6, 3);  // reset mid-frame
        send_frame(-1, -1, -1); frame_checks(7, 0);  // CHECK after reset
        send_frame(-1, -1, -1); frame_checks(8, 1);  // captured again

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
